// File: rtl/aes_tick_serializer_if.sv
// Load and byte-stream signals of the AES tick serializer.
// master = upstream block source / consumer side, slave = the serializer.
interface aes_tick_serializer_if #(
  parameter int BLOCK_W = 128,
  parameter int BYTE_W  = 8
) ();
  logic               load_valid;
  logic [BLOCK_W-1:0] load_data;
  logic               load_ready;
  logic [BYTE_W-1:0]  byte_out;
  logic               byte_valid;
  logic               busy;
  logic               done;

  modport master (
    output load_valid, load_data,
    input  load_ready, byte_out, byte_valid, busy, done
  );

  modport slave (
    input  load_valid, load_data,
    output load_ready, byte_out, byte_valid, busy, done
  );
endinterface

// File: rtl/aes_tick_serializer.sv
// Serializes one AES block MSB-byte-first, one byte per rising edge of the
// divided clk16 level. clk16 is only sampled as data in the clk50 domain.
module aes_tick_serializer #(
  parameter int BLOCK_W = 128,
  parameter int BYTE_W  = 8
) (
  input  logic                 clk50,
  input  logic                 reset,
  input  logic                 clk16,
  aes_tick_serializer_if.slave bus
);
  localparam int NBYTES = BLOCK_W / BYTE_W;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]         state_reg;
  logic               clk16_d_reg;
  logic [BLOCK_W-1:0] shreg_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               last_reg;     // final byte went out last cycle
  logic [BYTE_W-1:0]  byte_out_reg;
  logic               byte_valid_reg;
  logic               tick;

  assign tick = clk16 & ~clk16_d_reg;

  // Previous clk16 level for rising-edge detection.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      clk16_d_reg <= 1'b0;
    end else begin
      clk16_d_reg <= clk16;
    end
  end

  // Block capture, byte shifting and the IDLE/SHIFT/DONE sequence.
  // The SHIFT->DONE step waits one cycle after the last strobe so the final
  // byte_valid is still inside SHIFT and done follows it by one cycle.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      shreg_reg      <= '0;
      count_reg      <= '0;
      last_reg       <= 1'b0;
      byte_out_reg   <= '0;
      byte_valid_reg <= 1'b0;
    end else begin
      byte_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // A tick coinciding with acceptance is deliberately ignored.
          if (bus.load_valid) begin
            shreg_reg <= bus.load_data;
            count_reg <= '0;
            last_reg  <= 1'b0;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          if (last_reg) begin
            last_reg  <= 1'b0;
            state_reg <= DONE;
          end else if (tick) begin
            byte_out_reg   <= shreg_reg[BLOCK_W-1 -: BYTE_W];
            byte_valid_reg <= 1'b1;
            shreg_reg      <= {shreg_reg[BLOCK_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
            if (count_reg == LAST_IDX) begin
              last_reg <= 1'b1;
            end else begin
              count_reg <= count_reg + CNT_W'(1);
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.load_ready = (state_reg == IDLE);
  assign bus.busy       = (state_reg == SHIFT);
  assign bus.done       = (state_reg == DONE);
  assign bus.byte_out   = byte_out_reg;
  assign bus.byte_valid = byte_valid_reg;
endmodule

// File: tb/tb_aes_tick_serializer.sv
// Directed + randomized bench for aes_tick_serializer with a timestamp/queue
// reference model of the byte stream.
module tb_aes_tick_serializer;
  logic clk50 = 1'b0;
  logic reset;
  logic clk16;

  aes_tick_serializer_if bus_if ();

  aes_tick_serializer dut (
    .clk50 (clk50),
    .reset (reset),
    .clk16 (clk16),
    .bus   (bus_if)
  );

  always #5 clk50 = ~clk50;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Inputs staged for the next cycle, applied 1 time unit after posedge.
  logic         nx_reset = 1'b1;
  logic         nx_valid = 1'b0;
  logic [127:0] nx_data  = '0;
  bit           fast_toggle = 1'b1;
  logic [3:0]   div_cnt = 4'd0;

  // Reference model: pending bytes plus the cycles where things must happen.
  logic [7:0] q[$];
  int   acc_cyc  = -100;
  int   last_cyc = -100;
  int   done_cyc = -100;
  logic m_prev   = 1'b0;
  logic       e_bv = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_ready = 1'b1;
  logic [7:0] e_bo = 8'h00;
  bit   accepted_now = 1'b0;

  // Observations of the DUT for directed checks.
  int blk_strobes = 0, done_seen = 0, first_sv = 0, last_sv = 0, prev_sv = 0;
  int done_obs = 0, acc_obs = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [7:0] p_bo;
    logic       p_bv;
    logic       tk;
    int         k;
    if (reset === 1'b1) begin
      e_bv = 1'b0; e_bo = 8'h00; e_busy = 1'b0; e_done = 1'b0; e_ready = 1'b1;
    end
    chk("load_ready", bus_if.load_ready, e_ready);
    chk("busy",       bus_if.busy,       e_busy);
    chk("done",       bus_if.done,       e_done);
    chk("byte_valid", bus_if.byte_valid, e_bv);
    chk("byte_out",   bus_if.byte_out,   e_bo);

    if (bus_if.byte_valid === 1'b1) begin
      blk_strobes++;
      if (blk_strobes == 1) first_sv = cycle;
      else chk("strobe_gap", cycle - prev_sv, 16);
      prev_sv = cycle;
      last_sv = cycle;
      $display("cycle %0d: byte %0d = 0x%02h", cycle, blk_strobes - 1, bus_if.byte_out);
    end
    if (bus_if.done === 1'b1) begin
      done_seen++;
      done_obs = cycle;
      $display("cycle %0d: done", cycle);
    end
    if (bus_if.load_valid === 1'b1 && bus_if.load_ready === 1'b1 && reset === 1'b0) begin
      acc_obs = cycle;
      $display("cycle %0d: load accepted 0x%032h", cycle, bus_if.load_data);
    end

    p_bo = e_bo;
    p_bv = 1'b0;
    accepted_now = 1'b0;
    if (reset === 1'b1) begin
      q.delete();
      acc_cyc = -100; last_cyc = -100; done_cyc = -100;
      m_prev = 1'b0;
      p_bo = 8'h00;
    end else begin
      tk = clk16 & ~m_prev;
      if (q.size() > 0 && tk) begin
        p_bv = 1'b1;
        p_bo = q.pop_front();
        if (q.size() == 0) begin
          last_cyc = cycle + 1;
          done_cyc = cycle + 2;
        end
      end else if (e_ready && bus_if.load_valid === 1'b1) begin
        acc_cyc = cycle;
        accepted_now = 1'b1;
        for (int i = 0; i < 16; i++) q.push_back(bus_if.load_data[127-8*i -: 8]);
      end
      m_prev = clk16;
    end
    k = cycle + 1;
    e_bv    = p_bv;
    e_bo    = p_bo;
    e_done  = (k == done_cyc);
    e_busy  = (k > acc_cyc) && (q.size() > 0 || k <= last_cyc);
    e_ready = (q.size() == 0) && !(k > acc_cyc && k <= done_cyc);
  endtask

  task automatic cyc();
    @(posedge clk50);
    #1;
    reset = nx_reset;
    bus_if.load_valid = nx_valid;
    bus_if.load_data  = nx_data;
    if (fast_toggle) begin
      clk16 = ~clk16;
    end else begin
      div_cnt = div_cnt + 4'd1;
      clk16   = div_cnt[3];
    end
    @(negedge clk50);
    cycle++;
    model_step();
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic wait_accept(input int budget);
    int c = 0;
    do begin cyc(); c++; end while (!accepted_now && c < budget);
    chk("accept_timeout", accepted_now, 1);
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    do begin cyc(); c++; end while (bus_if.done !== 1'b1 && c < budget);
    chk("done_timeout", bus_if.done, 1);
  endtask

  task automatic wait_strobes(input int n, input int budget);
    int c = 0;
    int target;
    target = blk_strobes + n;
    while (blk_strobes < target && c < budget) begin cyc(); c++; end
    chk("strobe_timeout", blk_strobes >= target, 1);
  endtask

  task automatic new_block();
    blk_strobes = 0;
    done_seen   = 0;
  endtask

  function automatic logic [127:0] rnd_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int db;
    int guard;
    reset = 1'b1;
    clk16 = 1'b0;
    bus_if.load_valid = 1'b0;
    bus_if.load_data  = '0;

    // Reset held with clk16 toggling every cycle.
    run(4);
    chk("rst_ready", bus_if.load_ready, 1);
    chk("rst_busy",  bus_if.busy, 0);

    fast_toggle = 1'b0;
    div_cnt = 4'd0;
    nx_reset = 1'b0;
    run(3);

    // Counting block with the divider running.
    new_block();
    nx_data  = 128'h000102030405060708090a0b0c0d0e0f;
    nx_valid = 1'b1;
    wait_accept(50);
    nx_valid = 1'b0;
    wait_done(400);
    chk("a_strobes",    blk_strobes, 16);
    chk("a_done_count", done_seen, 1);
    chk("a_done_lag",   done_obs - last_sv, 1);
    chk("a_span",       last_sv - first_sv, 240);
    run(3);

    // load_valid held high across two blocks.
    new_block();
    nx_data  = rnd_block();
    nx_valid = 1'b1;
    wait_accept(50);
    nx_data = rnd_block();
    wait_done(400);
    chk("b_strobes", blk_strobes, 16);
    db = done_obs;
    new_block();
    wait_accept(5);
    chk("c_accept_after_done", acc_obs - db, 1);

    // All-ones offered while the block is shifting.
    nx_data = {128{1'b1}};
    wait_strobes(5, 200);
    nx_valid = 1'b0;
    wait_done(400);
    chk("c_strobes",    blk_strobes, 16);
    chk("c_done_count", done_seen, 1);
    run(20);
    chk("ff_not_loaded_ready", bus_if.load_ready, 1);
    chk("ff_not_loaded_busy",  bus_if.busy, 0);

    // Acceptance in the same cycle as a clk16 rise.
    guard = 0;
    while (div_cnt != 4'd7 && guard < 32) begin cyc(); guard++; end
    new_block();
    nx_data  = rnd_block();
    nx_valid = 1'b1;
    cyc();
    chk("tick_same_accept", accepted_now, 1);
    chk("tick_same_clk16",  clk16, 1);
    nx_valid = 1'b0;
    wait_done(400);
    chk("tick_first_latency", first_sv - acc_obs, 17);
    chk("tick_strobes", blk_strobes, 16);
    run(5);

    // Reset after byte 5 of a block.
    new_block();
    nx_data  = 128'h0f0e0d0c0b0a09080706050403020100;
    nx_valid = 1'b1;
    wait_accept(50);
    nx_valid = 1'b0;
    wait_strobes(6, 200);
    nx_reset = 1'b1;
    cyc();
    chk("mid_rst_busy",     bus_if.busy, 0);
    chk("mid_rst_byte_out", bus_if.byte_out, 0);
    chk("mid_rst_ready",    bus_if.load_ready, 1);
    run(1);
    nx_reset = 1'b0;
    run(40);
    chk("mid_rst_no_done", done_seen, 0);

    // Fresh block after the reset.
    new_block();
    nx_data  = rnd_block();
    nx_valid = 1'b1;
    wait_accept(50);
    nx_valid = 1'b0;
    wait_done(400);
    chk("fresh_strobes", blk_strobes, 16);
    chk("fresh_done",    done_seen, 1);

    // Random blocks with random idle gaps.
    for (int b = 0; b < 3; b++) begin
      run($urandom_range(0, 20));
      new_block();
      nx_data  = rnd_block();
      nx_valid = 1'b1;
      wait_accept(50);
      nx_valid = 1'b0;
      wait_done(400);
      chk("rand_strobes", blk_strobes, 16);
    end
    run(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
